scan_mux: RTL

Parametrised N-channel, W-bit registered selector with a manual-select mode and an auto-scan mode that walks the channels in order with a programmable dwell gap. Each selected sample is presented through a valid/ready output register, together with its channel index. It replaces fixed-width combinational selectors wherever a downstream consumer needs selected data paced, tagged and back-pressurable. N need not be a power of two; wrap-around is at N-1.

---
 rtl/scan_mux_if.sv | 38 +++
 rtl/scan_mux.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/scan_mux_if.sv
// Bus bundle for scan_mux: channel inputs, control and the valid/ready output beat.
// The mask signal exists only when SCAN_MASK_EN is defined.
interface scan_mux_if #(
    parameter int unsigned N       = 10,
    parameter int unsigned W       = 1,
    parameter int unsigned DWELL_W = 4
);
    localparam int unsigned SW = $clog2(N);

    logic [N*W-1:0]     din;
    logic               mode;
    logic [SW-1:0]      sel;
    logic [DWELL_W-1:0] dwell;
    logic               out_ready;
    logic               out_valid;
    logic [W-1:0]       dout;
    logic [SW-1:0]      out_ch;
    logic               wrap;
`ifdef SCAN_MASK_EN
    logic [N-1:0]       mask;
`endif

    modport master (
`ifdef SCAN_MASK_EN
        output mask,
`endif
        output din, mode, sel, dwell, out_ready,
        input  out_valid, dout, out_ch, wrap
    );

    modport slave (
`ifdef SCAN_MASK_EN
        input  mask,
`endif
        input  din, mode, sel, dwell, out_ready,
        output out_valid, dout, out_ch, wrap
    );
endinterface

// File: rtl/scan_mux.sv
// N-channel registered selector with manual select and auto-scan (dwell gap), valid/ready output.
// Define SCAN_MASK_EN to add a per-channel scan enable mask.
module scan_mux #(
    parameter int unsigned N       = 10,
    parameter int unsigned W       = 1,
    parameter int unsigned DWELL_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    scan_mux_if.slave  bus
);
    localparam int unsigned SW = $clog2(N);

    typedef enum logic [1:0] {StLoad, StHold, StGap} state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      ptr_q, ptr_d;
    logic [DWELL_W-1:0] gap_q, gap_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       dout_q, dout_d;
    logic [SW-1:0]      out_ch_q, out_ch_d;
    logic               wrap_q, wrap_d;
    logic               scan_q, scan_d;

    logic [N-1:0]       chan_en;
    logic               any_en;
    logic [SW-1:0]      first_en;
    logic [SW-1:0]      nxt_ptr;
    int unsigned        nxt_idx;
    logic               sel_ok;
    logic               free;
    logic               do_load;
    logic [SW-1:0]      load_ptr;
    logic [SW-1:0]      ld_ch;

`ifdef SCAN_MASK_EN
    assign chan_en = bus.mask;
`else
    assign chan_en = '1;
`endif
    assign any_en = |chan_en;
    assign free   = !out_valid_q || bus.out_ready;

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] ch);
        logic [W-1:0] r;
        r = '0;
        for (int c = 0; c < int'(N); c++) begin
            if (ch == SW'(c)) r = d[c*W +: W];
        end
        return r;
    endfunction

    // Lowest enabled channel, and the next enabled channel searching cyclically from ptr+1.
    always_comb begin
        first_en = '0;
        for (int c = int'(N) - 1; c >= 0; c--) begin
            if (chan_en[c]) first_en = SW'(c);
        end
        nxt_ptr = ptr_q;
        nxt_idx = 0;
        for (int i = int'(N) - 1; i >= 1; i--) begin
            nxt_idx = 32'(ptr_q) + 32'(i);
            if (nxt_idx >= N) nxt_idx = nxt_idx - N;
            if (chan_en[nxt_idx]) nxt_ptr = SW'(nxt_idx);
        end
    end

    always_comb begin
        sel_ok = 1'b0;
        for (int c = 0; c < int'(N); c++) begin
            if (bus.sel == SW'(c)) sel_ok = chan_en[c];
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gap_d       = gap_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        out_ch_d    = out_ch_q;
        wrap_d      = 1'b0;
        scan_d      = scan_q;
        do_load     = 1'b0;
        load_ptr    = ptr_q;
        ld_ch       = '0;

        unique case (state_q)
            StLoad: do_load = free;
            StHold: begin
                if (bus.out_ready) begin
                    ptr_d    = nxt_ptr;
                    load_ptr = nxt_ptr;
                    wrap_d   = (nxt_ptr < ptr_q);
                    if (bus.mode && (bus.dwell != '0)) begin
                        gap_d       = bus.dwell;
                        out_valid_d = 1'b0;
                        state_d     = StGap;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            StGap: begin
                gap_d = gap_q - 1'b1;
                // The last gap cycle loads directly so the beat period is dwell+1.
                if (!bus.mode || (gap_q <= 1)) do_load = 1'b1;
            end
            default: state_d = StLoad;
        endcase

        if (do_load) begin
            gap_d = '0;
            if (bus.mode) begin
                if (!any_en) begin
                    out_valid_d = 1'b0;
                    scan_d      = 1'b0;
                    state_d     = StLoad;
                end else begin
                    ld_ch       = scan_q ? load_ptr : first_en;
                    ptr_d       = ld_ch;
                    out_ch_d    = ld_ch;
                    dout_d      = pick(bus.din, ld_ch);
                    out_valid_d = 1'b1;
                    scan_d      = 1'b1;
                    state_d     = StHold;
                end
            end else begin
                scan_d  = 1'b0;
                state_d = StLoad;
                if (sel_ok) begin
                    dout_d      = pick(bus.din, bus.sel);
                    out_ch_d    = bus.sel;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_ch_q    <= '0;
            wrap_q      <= 1'b0;
            scan_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gap_q       <= gap_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            out_ch_q    <= out_ch_d;
            wrap_q      <= wrap_d;
            scan_q      <= scan_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.wrap      = wrap_q;
endmodule
